// File: rtl/clock_div_multi_prog_pkg.sv
// clock_div_multi_prog_pkg
// Purpose: shared constants and types for the multi-channel clock divider.
// No ports (package).
package clock_div_multi_prog_pkg;

`include "clock_div_defs.vh"

  localparam int CD_CNT_W       = `CLOCK_DIV_CNT_W;
  localparam int CD_DIV_DEFAULT = `CLOCK_DIV_DIV_DEFAULT;
  localparam int CD_CLK_IN_HZ   = `CLOCK_DIV_CLK_IN_HZ;
  localparam int CD_TICK_HZ     = `CLOCK_DIV_TICK_HZ;
  localparam int CD_RATIO       = CD_CLK_IN_HZ / CD_TICK_HZ;

  // What a channel does on the coming edge.
  typedef enum logic [1:0] {
    CH_STOP,   // EN low: park outputs, settle the divisor
    CH_START,  // EN just went high: begin a fresh period
    CH_WRAP,   // last count of a period: begin the next period
    CH_COUNT   // anywhere else inside a period
  } ch_action_t;

endpackage

// File: rtl/clock_div_channel.sv
// clock_div_channel
// Purpose: one channel of the programmable divider. Holds the active divisor,
// a pending divisor with its flag, the in-period counter and the run flag.
// Ports:
//   i_clk      system clock (rising edge)
//   i_rst_n    asynchronous active-low reset
//   i_en       run enable, level-sensitive
//   i_div_load one-cycle strobe capturing i_div_in
//   i_div_in   divisor value (unsigned)
//   o_clk_out  divided square wave (registered)
//   o_tick_out one-cycle strobe at period start (registered)
//   o_err      combinational: current load carries an illegal divisor (< 2)
module clock_div_channel
  import clock_div_multi_prog_pkg::*;
#(
  parameter int CNT_W       = CD_CNT_W,
  parameter int DIV_DEFAULT = CD_DIV_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_div_load,
  input  logic [CNT_W-1:0] i_div_in,
  output logic             o_clk_out,
  output logic             o_tick_out,
  output logic             o_err
);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_flag;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_clk_out;
  logic             r_tick;

  logic             w_load_ok;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_high;
  logic [CNT_W-1:0] w_div_new;
  ch_action_t       w_action;

  always_comb begin
    w_load_ok = i_div_load && (i_div_in >= CNT_W'(2));
    o_err     = i_div_load && (i_div_in <  CNT_W'(2));
    w_wrap    = (r_cnt == (r_div - CNT_W'(1)));
    // Cannot overflow: only used when r_cnt < r_div - 1.
    w_cnt_inc = r_cnt + CNT_W'(1);
    // Odd divisors spend the extra cycle in the high phase.
    w_high    = r_div - (r_div >> 1);
    // Divisor for a period starting on this edge (or settled on disable):
    // a coincident legal load beats an older pending value.
    w_div_new = w_load_ok   ? i_div_in :
                r_pend_flag ? r_pend   : r_div;

    w_action = CH_COUNT;
    if (!i_en)       w_action = CH_STOP;
    else if (!r_run) w_action = CH_START;
    else if (w_wrap) w_action = CH_WRAP;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div       <= CNT_W'(DIV_DEFAULT);
      r_pend      <= '0;
      r_pend_flag <= 1'b0;
      r_cnt       <= '0;
      r_run       <= 1'b0;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      case (w_action)
        CH_STOP: begin
          r_run       <= 1'b0;
          r_cnt       <= '0;
          r_clk_out   <= 1'b0;
          r_tick      <= 1'b0;
          r_div       <= w_div_new;
          r_pend_flag <= 1'b0;
        end
        CH_START, CH_WRAP: begin
          r_run       <= 1'b1;
          r_cnt       <= '0;
          r_div       <= w_div_new;
          r_pend_flag <= 1'b0;
          r_clk_out   <= 1'b1;
          r_tick      <= 1'b1;
        end
        CH_COUNT: begin
          r_cnt     <= w_cnt_inc;
          r_clk_out <= (w_cnt_inc < w_high);
          r_tick    <= 1'b0;
          if (w_load_ok) begin
            r_pend      <= i_div_in;
            r_pend_flag <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_clk_out  = r_clk_out;
  assign o_tick_out = r_tick;

endmodule

// File: rtl/clock_div_defs.vh
// clock_div_defs.vh
// Shared constants for the programmable clock divider.
//   - default counter width and reset divisor
//   - CLK_IN / tick-rate ratio constants used by the timing tree
`ifndef CLOCK_DIV_DEFS_VH
`define CLOCK_DIV_DEFS_VH

`define CLOCK_DIV_CNT_W       17
`define CLOCK_DIV_DIV_DEFAULT 1000
`define CLOCK_DIV_CLK_IN_HZ   1000000
`define CLOCK_DIV_TICK_HZ     1000

`endif

// File: rtl/clock_div_multi_prog.sv
// clock_div_multi_prog
// Purpose: NUM_CH independent programmable clock dividers sharing one
// divisor input bus, with a combined registered illegal-divisor pulse.
// Ports:
//   i_clk_in     system clock (rising edge)
//   i_reset_n    asynchronous active-low reset
//   i_en         per-channel run enable
//   i_div_load   per-channel load strobe for i_div_in
//   i_div_in     shared divisor value
//   o_clk_out    per-channel divided square wave
//   o_tick_out   per-channel period-start strobe
//   o_div_err    one-cycle pulse after any load with i_div_in < 2
module clock_div_multi_prog
  import clock_div_multi_prog_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CD_CNT_W,
  parameter int DIV_DEFAULT = CD_DIV_DEFAULT
) (
  input  logic              i_clk_in,
  input  logic              i_reset_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic [NUM_CH-1:0] i_div_load,
  input  logic [CNT_W-1:0]  i_div_in,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick_out,
  output logic              o_div_err
);

  logic [NUM_CH-1:0] w_err;
  logic              r_div_err;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clock_div_channel #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
      ) u_ch (
        .i_clk      (i_clk_in),
        .i_rst_n    (i_reset_n),
        .i_en       (i_en[gi]),
        .i_div_load (i_div_load[gi]),
        .i_div_in   (i_div_in),
        .o_clk_out  (o_clk_out[gi]),
        .o_tick_out (o_tick_out[gi]),
        .o_err      (w_err[gi])
      );
    end
  endgenerate

  // Bad loads on several channels in one cycle collapse into one pulse.
  always_ff @(posedge i_clk_in or negedge i_reset_n) begin
    if (!i_reset_n) r_div_err <= 1'b0;
    else            r_div_err <= |w_err;
  end

  assign o_div_err = r_div_err;

endmodule

// File: doc/clock_div_multi_prog.md
# clock_div_multi_prog

Parametrised, multi-channel programmable clock divider for the avionics timing tree. Each of NUM_CH channels divides CLK_IN by a runtime-loadable integer D ≥ 2. Each channel produces a near-50% square wave plus a one-cycle tick strobe aligned to its rising edge. The block replaces the fixed-ratio dividers: channel 0 at reset yields 1 kHz from a 1 MHz CLK_IN, and further channels supply sensor/telemetry sample rates.

## Interface
- NUM_CH, 4: number of independent channels (1..8)
- CNT_W, 17: counter/divisor width in bits
- DIV_DEFAULT, 1000: divisor loaded into every channel at reset (must be ≥ 2)

- CLK_IN  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- EN  in  NUM_CH  per-channel run enable, level-sensitive
- DIV_LOAD  in  NUM_CH  per-channel one-cycle strobe; captures DIV_IN
- DIV_IN  in  CNT_W  shared divisor value, unsigned
- CLK_OUT  out  NUM_CH  divided square wave, registered
- TICK_OUT  out  NUM_CH  one-cycle strobe at each period start, registered
- DIV_ERR  out  1  one-cycle pulse when any DIV_LOAD carries DIV_IN < 2

## Operation
- Per channel state: active divisor D, pending divisor P, pending flag PF, counter C (0..D-1), run flag R.
- High time H = D − floor(D/2) cycles, low time floor(D/2); odd D is high one cycle longer. D=2 gives 1 high / 1 low.
- Running (EN=1, R=1): each edge C_next = (C==D−1) ? 0 : C+1; CLK_OUT <= (C_next < H); TICK_OUT <= (C_next==0).
- Wrap (C==D−1 → 0): if PF, then D <= P and PF <= 0. The new D governs the period starting at that wrap.
- DIV_LOAD with DIV_IN ≥ 2: P <= DIV_IN, PF <= 1. If this coincides with a wrap edge, DIV_IN is applied directly at that wrap. Repeated loads before a wrap: last one wins.
- DIV_LOAD with DIV_IN < 2: ignored (P, PF, D unchanged); DIV_ERR pulses high next cycle. Simultaneous bad loads on several channels give a single pulse.
- Disabled (EN=0): on the next edge R <= 0, C <= 0, CLK_OUT <= 0, TICK_OUT <= 0. A DIV_LOAD while disabled writes D directly (PF cleared). A pending PF is applied on disable.
- Enable (EN=1 with R=0): on that edge R <= 1, C <= 0, CLK_OUT <= 1, TICK_OUT <= 1. A new period starts with no partial period.
- Channels are fully independent. There is no phase relation between channels unless enabled on the same edge with equal D; in that case outputs are bit-identical.
- Counter never exceeds D−1. The maximum divisor is 2^CNT_W − 1.

## Timing
- Reset (RESET=0, asynchronous): D = DIV_DEFAULT, P = 0, PF = 0, C = 0, R = 0, CLK_OUT = 0, TICK_OUT = 0, DIV_ERR = 0 on all channels.
- Reset mid-period aborts immediately. After release, a channel with EN=1 starts on the first edge: CLK_OUT=1, TICK_OUT=1.
- Enable latency: 1 edge from EN sampled high to CLK_OUT/TICK_OUT high.
- Disable latency: 1 edge from EN sampled low to CLK_OUT low. Truncated high or low phases are permitted.
- TICK_OUT rises on the same edge as CLK_OUT rises and lasts exactly one CLK_IN cycle.
- DIV_LOAD to effect: at the next wrap edge. Worst case is D_old cycles.
- DIV_ERR: asserted on the edge after the offending DIV_LOAD, for one cycle.

## Structure
- Shared include clock_div_defs.vh holds:
  - default CNT_W and DIV_DEFAULT;
  - the 1 MHz / 1 kHz ratio constants used elsewhere in the design.
- Sub-module clock_div_channel implements one channel's D/P/PF/C/R/outputs and a local error flag. The top instantiates NUM_CH copies via generate, slices EN, DIV_LOAD, CLK_OUT and TICK_OUT, and ORs the per-channel error flags into registered DIV_ERR.

## Test plan
- Reset release, EN=4'b0001, 1 MHz CLK_IN, defaults: CLK_OUT[0] has period 1000 cycles, high 500. TICK_OUT[0] occurs once per 1000 cycles. Channels 1–3 stay low.
- Odd divisor: load DIV_IN=7 on ch1 while disabled, then enable. CLK_OUT[1] is high 4 / low 3, period 7; first edge after EN shows CLK_OUT=1, TICK=1.
- Mid-period reprogram: ch2 running D=10, DIV_LOAD=4 at C=3, then DIV_LOAD=6 at C=5. The current period completes at 10 cycles, then D=6 periods follow; 4 is never applied.
- Load on the wrap edge: ch0 D=8, DIV_LOAD=3 exactly at C=7. The very next period is 3 cycles (high 2, low 1).
- Illegal load: DIV_IN=1 on ch3 and DIV_IN=0 on ch1 in the same cycle. DIV_ERR is high for exactly 1 cycle; both channels keep their D and continue.
- Asynchronous reset asserted mid-high phase with EN held high: all outputs go 0 immediately. After release, CLK_OUT rises on the first edge with D=1000 restored.
